// File: rtl/asmi_arbiter.sv
// Round-robin arbiter sharing one ASMI flash controller between a program and a read-back port.
// Define ASMI_TIMEOUT_EN to add a watchdog that aborts LOAD/WAIT_FALL/WAIT_DATA after TIMEOUT_CYCLES.
module asmi_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd500000000,
  parameter int unsigned BUSY_RISE_MAX  = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic        shift0,
  input  logic        shift1,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [23:0] asmi_addr,
  output logic        asmi_wren,
  output logic        asmi_sector_erase,
  output logic        asmi_write,
  output logic        asmi_read,
  output logic        asmi_shift_bytes,
  output logic [7:0]  asmi_datain,
  input  logic        asmi_busy,
  input  logic        asmi_data_valid,
  input  logic [7:0]  asmi_dataout
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StIssue, StWaitRise, StWaitFall, StWaitData, StFinish
  } state_e;

  state_e      state_q, state_d;
  logic        busy_q, dv_q;
  logic [7:0]  dout_q;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [1:0]  op_q, op_d;
  logic [23:0] addr_q, addr_d;
  logic        seen_q, seen_d;
  logic [31:0] cnt_q, cnt_d;
  logic        fail;
  logic        counting;

  logic [1:0]  grant_q, grant_d, done_q, done_d;
  logic        err_q, err_d, wren_q, wren_d, erase_q, erase_d;
  logic        write_q, write_d, read_q, read_d, shift_q, shift_d;
  logic [7:0]  datain_q, datain_d, rdata_q, rdata_d;

  logic        pick, sel_shift;
  logic [7:0]  sel_data;

  // On a tie the port not served last wins.
  assign pick      = (req == 2'b11) ? ~last_q : req[1];
  assign sel_shift = owner_q ? shift1 : shift0;
  assign sel_data  = owner_q ? data1 : data0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      dv_q     <= 1'b0;
      dout_q   <= 8'h00;
      last_q   <= 1'b0;
      owner_q  <= 1'b0;
      op_q     <= 2'd0;
      addr_q   <= 24'h0;
      seen_q   <= 1'b0;
      cnt_q    <= 32'd0;
      grant_q  <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 1'b0;
      wren_q   <= 1'b0;
      erase_q  <= 1'b0;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
      shift_q  <= 1'b0;
      datain_q <= 8'h00;
      rdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      busy_q   <= asmi_busy;
      dv_q     <= asmi_data_valid;
      dout_q   <= asmi_dataout;
      last_q   <= last_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      seen_q   <= seen_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wren_q   <= wren_d;
      erase_q  <= erase_d;
      write_q  <= write_d;
      read_q   <= read_d;
      shift_q  <= shift_d;
      datain_q <= datain_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    addr_d  = addr_q;
    last_d  = last_q;
    seen_d  = seen_q;
    fail    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Both the raw and registered busy must be low so a post-reset busy ASMI is respected.
        if ((req != 2'b00) && !busy_q && !asmi_busy) begin
          owner_d = pick;
          op_d    = pick ? op1 : op0;
          addr_d  = pick ? addr1 : addr0;
          seen_d  = 1'b0;
          if (op_d == 2'd0) begin
            state_d = StFinish;
            fail    = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (op_q != 2'd2) begin
          state_d = StIssue;
        end else if (sel_shift) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          state_d = StIssue;
        end
      end
      StIssue:    state_d = (op_q == 2'd3) ? StWaitData : StWaitRise;
      StWaitRise: begin
        if (busy_q) begin
          state_d = StWaitFall;
        end else if ((cnt_q + 32'd1) >= BUSY_RISE_MAX) begin
          state_d = StFinish;
        end
      end
      StWaitFall: if (!busy_q) state_d = StFinish;
      StWaitData: if (dv_q) state_d = StFinish;
      StFinish: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default:    state_d = StIdle;
    endcase
`ifdef ASMI_TIMEOUT_EN
    counting = (state_q == StWaitRise) || (state_q == StLoad) ||
               (state_q == StWaitFall) || (state_q == StWaitData);
    if ((state_q == StLoad || state_q == StWaitFall || state_q == StWaitData) &&
        (state_d == state_q) && ((cnt_q + 32'd1) >= TIMEOUT_CYCLES)) begin
      state_d = StFinish;
      fail    = 1'b1;
    end
`else
    counting = (state_q == StWaitRise);
`endif
    // Counter restarts on every state entry.
    if (state_d != state_q) begin
      cnt_d = 32'd0;
    end else if (counting) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

`ifndef ASMI_TIMEOUT_EN
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    grant_d = grant_q;
    if (state_q == StIdle && state_d != StIdle) begin
      grant_d = owner_d ? 2'b10 : 2'b01;
    end else if (state_q == StFinish) begin
      grant_d = 2'b00;
    end
    done_d   = (state_d == StFinish) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
    err_d    = fail;
    wren_d   = (state_d == StLoad) || (state_d == StIssue);
    erase_d  = (state_d == StIssue) && (op_d == 2'd1);
    write_d  = (state_d == StIssue) && (op_d == 2'd2);
    read_d   = (state_d == StIssue) && (op_d == 2'd3);
    shift_d  = (state_q == StLoad) && (state_d == StLoad) && (op_q == 2'd2) && sel_shift;
    datain_d = shift_d ? sel_data : datain_q;
    rdata_d  = (state_q == StWaitData && dv_q) ? dout_q : rdata_q;
  end

  assign grant             = grant_q;
  assign done              = done_q;
  assign err               = err_q;
  assign rdata             = rdata_q;
  assign asmi_addr         = addr_q;
  assign asmi_wren         = wren_q;
  assign asmi_sector_erase = erase_q;
  assign asmi_write        = write_q;
  assign asmi_read         = read_q;
  assign asmi_shift_bytes  = shift_q;
  assign asmi_datain       = datain_q;

endmodule

// File: tb/tb_asmi_arbiter.sv
// Directed self-checking bench for asmi_arbiter; inputs change and outputs are sampled on negedges.
module tb_asmi_arbiter;
  localparam int unsigned Tmo = 1500;

  logic        clock = 1'b0, reset_n = 1'b0;
  logic [1:0]  req = 2'b00, op0 = 2'd0, op1 = 2'd0;
  logic [23:0] addr0 = 24'h0, addr1 = 24'h0;
  logic        shift0 = 1'b0, shift1 = 1'b0;
  logic [7:0]  data0 = 8'h00, data1 = 8'h00;
  logic [1:0]  grant, done;
  logic        err;
  logic [7:0]  rdata;
  logic [23:0] asmi_addr;
  logic        asmi_wren, asmi_sector_erase, asmi_write, asmi_read, asmi_shift_bytes;
  logic [7:0]  asmi_datain;
  logic        asmi_busy = 1'b0, asmi_data_valid = 1'b0;
  logic [7:0]  asmi_dataout = 8'h00;

  int checks = 0, failures = 0;
  logic grant_both = 1'b0;

  asmi_arbiter #(.TIMEOUT_CYCLES(Tmo), .BUSY_RISE_MAX(15)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .op0(op0), .op1(op1),
    .addr0(addr0), .addr1(addr1), .shift0(shift0), .shift1(shift1),
    .data0(data0), .data1(data1), .grant(grant), .done(done), .err(err), .rdata(rdata),
    .asmi_addr(asmi_addr), .asmi_wren(asmi_wren), .asmi_sector_erase(asmi_sector_erase),
    .asmi_write(asmi_write), .asmi_read(asmi_read), .asmi_shift_bytes(asmi_shift_bytes),
    .asmi_datain(asmi_datain), .asmi_busy(asmi_busy), .asmi_data_valid(asmi_data_valid),
    .asmi_dataout(asmi_dataout)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (grant === 2'b11) grant_both <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clock);
  endtask

  logic [45:0] all_out;
  assign all_out = {grant, done, err, rdata, asmi_addr, asmi_wren, asmi_sector_erase,
                    asmi_write, asmi_read, asmi_shift_bytes, asmi_datain};

  initial begin
    int n, bad;
    nclk(2);
    chk("reset_outputs", {18'd0, all_out[45:32]}, 32'd0);
    chk("reset_outputs_lo", all_out[31:0], 32'd0);
    reset_n = 1'b1;
    nclk(1);

    // Sector erase on port 0 with busy held for 1000 cycles.
    req = 2'b01; op0 = 2'd1; addr0 = 24'h200000;
    nclk(1);
    chk("erase_grant", grant, 2'b01);
    nclk(1);
    chk("erase_strobe", {asmi_sector_erase, asmi_wren, asmi_write, asmi_read}, 4'b1100);
    chk("erase_addr", asmi_addr, 24'h200000);
    nclk(1);
    chk("erase_one_pulse", asmi_sector_erase, 1'b0);
    asmi_busy = 1'b1;
    nclk(1000);
    asmi_busy = 1'b0;
    nclk(1);
    chk("erase_done_early", done, 2'b00);
    nclk(1);
    chk("erase_done", {done, err}, {2'b01, 1'b0});
    req = 2'b00;
    nclk(1);
    chk("erase_release", {done, grant}, 4'b0000);

    // Tie after reset: port 1 (read 0x10) first, then port 0 (illegal op).
    reset_n = 1'b0;
    nclk(1);
    reset_n = 1'b1;
    req = 2'b11; op0 = 2'd0; op1 = 2'd3; addr1 = 24'h000010;
    nclk(1);
    chk("tie_grant_p1", grant, 2'b10);
    nclk(1);
    chk("read_strobe", {asmi_read, asmi_sector_erase, asmi_write}, 3'b100);
    chk("read_addr", asmi_addr, 24'h000010);
    nclk(1);
    asmi_dataout = 8'hA5; asmi_data_valid = 1'b1;
    nclk(1);
    asmi_dataout = 8'h00; asmi_data_valid = 1'b0;
    chk("read_done_early", done, 2'b00);
    nclk(1);
    chk("read_done", {done, err}, {2'b10, 1'b0});
    chk("read_rdata", rdata, 8'hA5);
    req = 2'b01;
    nclk(1);
    chk("grant_gap", {grant, done}, 4'b0000);
    nclk(1);
    chk("illegal_done", {grant, done, err}, {2'b01, 2'b01, 1'b1});
    chk("illegal_no_strobe", {asmi_wren, asmi_sector_erase, asmi_write, asmi_read}, 4'b0000);
    req = 2'b00;
    nclk(1);
    chk("illegal_release", {grant, done, err}, 5'b00000);

    // Page write: 256 shifts of 0x00..0xFF, then a fast op (busy never rises).
    req = 2'b01; op0 = 2'd2; addr0 = 24'h000100;
    nclk(1);
    chk("write_grant", grant, 2'b01);
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      shift0 = 1'b1; data0 = 8'(k);
      nclk(1);
      if (!(asmi_shift_bytes === 1'b1 && asmi_datain === 8'(k) && asmi_wren === 1'b1)) bad++;
    end
    chk("write_datain_stream", bad, 0);
    shift0 = 1'b0;
    nclk(1);
    chk("write_strobe", {asmi_write, asmi_shift_bytes, asmi_wren}, 3'b101);
    nclk(1);
    chk("write_one_pulse", {asmi_write, asmi_wren}, 2'b00);
    n = 0;
    while (done[0] !== 1'b1 && n < 40) begin
      nclk(1);
      n++;
    end
    chk("write_fast_latency", n, 15);
    chk("write_done", {done, err}, {2'b01, 1'b0});
    req = 2'b00;
    nclk(1);

    // Reset mid-erase clears outputs at once; ASMI busy then blocks the next grant.
    req = 2'b10; op1 = 2'd1; addr1 = 24'hABCDEF;
    nclk(2);
    chk("erase2_strobe", {asmi_sector_erase, asmi_addr}, {1'b1, 24'hABCDEF});
    asmi_busy = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_hi", {18'd0, all_out[45:32]}, 32'd0);
    chk("async_reset_lo", all_out[31:0], 32'd0);
    nclk(1);
    reset_n = 1'b1;
    nclk(3);
    chk("busy_blocks_grant", grant, 2'b00);
    asmi_busy = 1'b0;
    nclk(1);
    chk("busy_q_blocks_grant", grant, 2'b00);
    nclk(1);
    chk("grant_after_busy", grant, 2'b10);
    n = 0;
    while (done[1] !== 1'b1 && n < 40) begin
      nclk(1);
      n++;
    end
    chk("erase2_done", {done, err}, {2'b10, 1'b0});
    req = 2'b00;
    nclk(1);

`ifdef ASMI_TIMEOUT_EN
    // Busy stuck high: the watchdog finishes the erase with err.
    req = 2'b01; op0 = 2'd1; addr0 = 24'h010000;
    nclk(3);
    asmi_busy = 1'b1;
    n = 0;
    while (done[0] !== 1'b1 && n < int'(Tmo) + 50) begin
      nclk(1);
      n++;
    end
    chk("timeout_done", {done, err}, {2'b01, 1'b1});
    chk("timeout_window", (n >= int'(Tmo) && n <= int'(Tmo) + 10), 1'b1);
    req = 2'b00;
    asmi_busy = 1'b0;
    nclk(3);
`endif

    chk("grant_onehot", grant_both, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
